dmem_arbiter: RTL and testbench

//  Two-master arbiter between the scalar core data port (M0) and the MLP accelerator

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_arbiter_sat_counter.sv | 38 +++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the dmem arbiter slice.
//   - arb_state_e : arbiter FSM states
//   - master_id_e : identifies the core (M0) or the MLP DMA (M1) port
//   - MAX_LOCK    : default maximum M1 burst-lock length
//   - LOCK_W      : width of the burst-lock counter for MAX_LOCK
//   - lock_width(): lock counter width for any MaxLock (at least 1 bit)
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_id_e;

   function automatic int unsigned lock_width(input int unsigned max_lock);
      return (max_lock > 1) ? $clog2(max_lock) : 1;
   endfunction

   localparam int unsigned MAX_LOCK = 16;
   localparam int unsigned LOCK_W   = lock_width(MAX_LOCK);

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Completed-access counter that sticks at all-ones instead of wrapping.
//   clk_i  in   1         clock
//   rst_i  in   1         synchronous active-high reset (clears to 0)
//   inc_i  in   1         count one event this cycle
//   cnt_o  out  CntWidth  current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned CntWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                inc_i,
   output logic [CntWidth-1:0] cnt_o
);

   logic [CntWidth-1:0] cnt_q;
   logic [CntWidth-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Round-robin arbiter between the core data port (M0) and the MLP DMA port
//   (M1) in front of the single memory dmem port (S). M1 may hold the grant
//   across consecutive accesses with m1_lock_i, bounded by MaxLock.
//   Ports:
//     clk_i, rst_i                      clock, synchronous active-high reset
//     m0_req_i/write_i/addr_i/wdata_i   core request, held until m0_ready_o
//     m0_ready_o, m0_rdata_o            core completion pulse and load data
//     m1_*                              DMA port, same as m0_*
//     m1_lock_i                         sampled at M1 completion: keep grant
//     s_req_o/write_o/addr_o/wdata_o    forwarded request to memory
//     s_ready_i, s_rdata_i              memory completion pulse and load data
//     m0_cnt_o, m1_cnt_o                saturating completed-access counts
//     busy_o                            FSM not in IDLE
// ----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DWidth   = 32,
   parameter int unsigned MaxLock  = MAX_LOCK,
   parameter int unsigned CntWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                m0_req_i,
   input  logic                m0_write_i,
   input  logic [DWidth-1:0]   m0_addr_i,
   input  logic [DWidth-1:0]   m0_wdata_i,
   output logic                m0_ready_o,
   output logic [DWidth-1:0]   m0_rdata_o,
   input  logic                m1_req_i,
   input  logic                m1_write_i,
   input  logic [DWidth-1:0]   m1_addr_i,
   input  logic [DWidth-1:0]   m1_wdata_i,
   output logic                m1_ready_o,
   output logic [DWidth-1:0]   m1_rdata_o,
   input  logic                m1_lock_i,
   output logic                s_req_o,
   output logic                s_write_o,
   output logic [DWidth-1:0]   s_addr_o,
   output logic [DWidth-1:0]   s_wdata_o,
   input  logic                s_ready_i,
   input  logic [DWidth-1:0]   s_rdata_i,
   output logic [CntWidth-1:0] m0_cnt_o,
   output logic [CntWidth-1:0] m1_cnt_o,
   output logic                busy_o
);

   localparam int unsigned LockW = (MaxLock == MAX_LOCK) ? LOCK_W : lock_width(MaxLock);
   localparam logic [LockW-1:0] LockLast = LockW'(MaxLock - 1);

   arb_state_e       state_q;
   master_id_e       last_q;
   logic [LockW-1:0] lock_q;

   // Forwarding mux and completion decode; only the granted master sees s_*.
   always_comb begin
      s_req_o    = 1'b0;
      s_write_o  = 1'b0;
      s_addr_o   = '0;
      s_wdata_o  = '0;
      m0_ready_o = 1'b0;
      m1_ready_o = 1'b0;
      case (state_q)
         GNT0: begin
            s_req_o    = m0_req_i;
            s_write_o  = m0_write_i;
            s_addr_o   = m0_addr_i;
            s_wdata_o  = m0_wdata_i;
            m0_ready_o = m0_req_i && s_ready_i;
         end
         GNT1: begin
            s_req_o    = m1_req_i;
            s_write_o  = m1_write_i;
            s_addr_o   = m1_addr_i;
            s_wdata_o  = m1_wdata_i;
            m1_ready_o = m1_req_i && s_ready_i;
         end
         default: ;
      endcase
   end

   assign m0_rdata_o = s_rdata_i;
   assign m1_rdata_o = s_rdata_i;
   assign busy_o     = (state_q != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= M1;
         lock_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_req_i && m1_req_i) begin
                  state_q <= (last_q == M0) ? GNT1 : GNT0;
               end else if (m0_req_i) begin
                  state_q <= GNT0;
               end else if (m1_req_i) begin
                  state_q <= GNT1;
               end
            end
            GNT0: begin
               if (!m0_req_i) begin
                  state_q <= IDLE;
               end else if (s_ready_i) begin
                  state_q <= IDLE;
                  last_q  <= M0;
                  lock_q  <= '0;
               end
            end
            GNT1: begin
               if (!m1_req_i) begin
                  state_q <= IDLE;
                  lock_q  <= '0;
               end else if (s_ready_i) begin
                  last_q <= M1;
                  // lock_q counts extra locked accesses; MaxLock total per grant.
                  if (m1_lock_i && (lock_q < LockLast)) begin
                     lock_q <= lock_q + 1'b1;
                  end else begin
                     state_q <= IDLE;
                     lock_q  <= '0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               lock_q  <= '0;
            end
         endcase
      end
   end

   sat_counter #(.CntWidth(CntWidth)) u_m0_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (m0_ready_o),
      .cnt_o (m0_cnt_o)
   );

   sat_counter #(.CntWidth(CntWidth)) u_m1_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (m1_ready_o),
      .cnt_o (m1_cnt_o)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Expected accesses are queued in the order
//   the arbiter should grant them and compared as the memory side sees them.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m0_write_i;
   logic [31:0] m0_addr_i, m0_wdata_i;
   logic        m0_ready_o;
   logic [31:0] m0_rdata_o;
   logic        m1_req_i, m1_write_i;
   logic [31:0] m1_addr_i, m1_wdata_i;
   logic        m1_ready_o;
   logic [31:0] m1_rdata_o;
   logic        m1_lock_i;
   logic        s_req_o, s_write_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic        s_ready_i;
   logic [31:0] s_rdata_i;
   logic [31:0] m0_cnt_o, m1_cnt_o;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(.DWidth(32), .MaxLock(16), .CntWidth(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .m0_req_i   (m0_req_i),
      .m0_write_i (m0_write_i),
      .m0_addr_i  (m0_addr_i),
      .m0_wdata_i (m0_wdata_i),
      .m0_ready_o (m0_ready_o),
      .m0_rdata_o (m0_rdata_o),
      .m1_req_i   (m1_req_i),
      .m1_write_i (m1_write_i),
      .m1_addr_i  (m1_addr_i),
      .m1_wdata_i (m1_wdata_i),
      .m1_ready_o (m1_ready_o),
      .m1_rdata_o (m1_rdata_o),
      .m1_lock_i  (m1_lock_i),
      .s_req_o    (s_req_o),
      .s_write_o  (s_write_o),
      .s_addr_o   (s_addr_o),
      .s_wdata_o  (s_wdata_o),
      .s_ready_i  (s_ready_i),
      .s_rdata_i  (s_rdata_i),
      .m0_cnt_o   (m0_cnt_o),
      .m1_cnt_o   (m1_cnt_o),
      .busy_o     (busy_o)
   );

   typedef struct {
      bit          m;
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] exp_cnt [2];
   int          m0_idx = 0, m0_n = 0, m1_idx = 0, m1_n = 0, m0_trig = -1;

   function automatic logic [31:0] addr_of(input bit m, input int i);
      return (m ? 32'h0000_8000 : 32'h0000_4000) + 32'(i) * 32'd4;
   endfunction

   function automatic logic [31:0] wdata_of(input bit m, input int i);
      return {(m ? 16'hB1B1 : 16'hA0A0), 16'(i)};
   endfunction

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push_exp(input bit m, input int i);
      exp_t e;
      e.m     = m;
      e.w     = i[0];
      e.addr  = addr_of(m, i);
      e.wdata = wdata_of(m, i);
      sb.push_back(e);
   endtask

   // Bench masters: present access idx until it completes, then the next one.
   task automatic drive_m(input bit m);
      if (!m) begin
         m0_req_i   = (m0_idx < m0_n);
         m0_write_i = m0_idx[0];
         m0_addr_i  = addr_of(1'b0, m0_idx);
         m0_wdata_i = wdata_of(1'b0, m0_idx);
      end else begin
         m1_req_i   = (m1_idx < m1_n);
         m1_write_i = m1_idx[0];
         m1_addr_i  = addr_of(1'b1, m1_idx);
         m1_wdata_i = wdata_of(1'b1, m1_idx);
      end
   endtask

   task automatic advance(input bit m);
      if (!m) begin
         m0_idx++;
         drive_m(1'b0);
      end else begin
         m1_idx++;
         drive_m(1'b1);
         if (m1_idx == m0_trig) begin
            m0_n = m0_idx + 1;
            drive_m(1'b0);
         end
      end
   endtask

   // Entered and left at negedge+1. exp_gap: cycles until s_req_o, -1 = any.
   task automatic serve(input int lat, input int exp_gap);
      exp_t e;
      int   c;
      c = 0;
      while (s_req_o !== 1'b1 && c < 40) begin
         @(negedge clk_i); #1;
         c++;
      end
      if (s_req_o !== 1'b1) begin
         check("sreq_timeout", 32'(s_req_o), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check("sb_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      if (exp_gap >= 0) check("grant_gap", 32'(c), 32'(exp_gap));
      check("s_addr", s_addr_o, e.addr);
      check("s_write", 32'(s_write_o), 32'(e.w));
      check("s_wdata", s_wdata_o, e.wdata);
      repeat (lat) @(negedge clk_i);
      s_ready_i = 1'b1;
      s_rdata_i = rdata_of(e.addr);
      #1;
      check("granted_ready", 32'(e.m ? m1_ready_o : m0_ready_o), 32'd1);
      check("other_ready", 32'(e.m ? m0_ready_o : m1_ready_o), 32'd0);
      check("rdata", e.m ? m1_rdata_o : m0_rdata_o, rdata_of(e.addr));
      if (exp_cnt[e.m] != 32'hFFFF_FFFF) exp_cnt[e.m] = exp_cnt[e.m] + 32'd1;
      @(negedge clk_i);
      s_ready_i = 1'b0;
      s_rdata_i = '0;
      advance(e.m);
      #1;
      check(e.m ? "m1_cnt" : "m0_cnt", e.m ? m1_cnt_o : m0_cnt_o, exp_cnt[e.m]);
      check("ready_pulse", 32'({m0_ready_o, m1_ready_o}), 32'd0);
   endtask

   task automatic wait_sreq(input string tag);
      int c;
      c = 0;
      while (s_req_o !== 1'b1 && c < 40) begin
         @(negedge clk_i); #1;
         c++;
      end
      check(tag, 32'(s_req_o), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i     = 1'b1;
      m0_req_i  = 1'b0;
      m1_req_i  = 1'b0;
      m1_lock_i = 1'b0;
      s_ready_i = 1'b0;
      s_rdata_i = '0;
      m0_n      = m0_idx;
      m1_n      = m1_idx;
      m0_trig   = -1;
      sb.delete();
      repeat (2) @(negedge clk_i);
      rst_i      = 1'b0;
      exp_cnt[0] = '0;
      exp_cnt[1] = '0;
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      m0_req_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0;
      m1_req_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0;
      m1_lock_i = 1'b0; s_ready_i = 1'b0; s_rdata_i = '0;
      do_reset();
      check("rst_s_req", 32'(s_req_o), 32'd0);
      check("rst_ready", 32'({m0_ready_o, m1_ready_o}), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_m0_cnt", m0_cnt_o, 32'd0);
      check("rst_m1_cnt", m1_cnt_o, 32'd0);

      // 1: single M0 load to 0x4000, memory latency 3
      m0_n = m0_idx + 1;
      push_exp(1'b0, m0_idx);
      @(negedge clk_i);
      drive_m(1'b0);
      #1;
      check("t1_sreq_bubble", 32'(s_req_o), 32'd0);
      check("t1_addr_base", m0_addr_i, 32'h0000_4000);
      serve(3, 1);
      check("t1_busy_idle", 32'(busy_o), 32'd0);

      // 2: simultaneous requests after reset -> M0 then M1
      do_reset();
      m0_n = m0_idx + 1;
      m1_n = m1_idx + 1;
      push_exp(1'b0, m0_idx);
      push_exp(1'b1, m1_idx);
      @(negedge clk_i);
      drive_m(1'b0);
      drive_m(1'b1);
      #1;
      serve(2, 1);
      serve(2, 1);

      // 3: locked M1 stream of 20, M0 arrives during the second M1 access
      do_reset();
      m1_lock_i = 1'b1;
      m1_n      = m1_idx + 20;
      m0_trig   = m1_idx + 1;
      for (int k = 0; k < 16; k++) push_exp(1'b1, m1_idx + k);
      push_exp(1'b0, m0_idx);
      for (int k = 16; k < 20; k++) push_exp(1'b1, m1_idx + k);
      @(negedge clk_i);
      drive_m(1'b1);
      #1;
      serve(1, 1);
      for (int k = 1; k < 16; k++) serve(1, 0);
      serve(1, 1);
      serve(1, 1);
      for (int k = 17; k < 20; k++) serve(1, 0);
      @(negedge clk_i);
      m1_lock_i = 1'b0;
      m0_trig   = -1;
      #1;
      check("t3_release", 32'(busy_o), 32'd0);

      // 4: reset while M1 is granted, then a late s_ready_i
      do_reset();
      m1_n = m1_idx + 1;
      @(negedge clk_i);
      drive_m(1'b1);
      #1;
      wait_sreq("t4_grant");
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i     = 1'b0;
      m1_req_i  = 1'b0;
      m1_n      = m1_idx;
      s_ready_i = 1'b1;
      s_rdata_i = 32'hDEAD_BEEF;
      #1;
      check("t4_s_req", 32'(s_req_o), 32'd0);
      check("t4_m1_ready", 32'(m1_ready_o), 32'd0);
      check("t4_m0_ready", 32'(m0_ready_o), 32'd0);
      @(negedge clk_i);
      s_ready_i = 1'b0;
      #1;
      check("t4_m1_cnt", m1_cnt_o, 32'd0);
      check("t4_busy", 32'(busy_o), 32'd0);

      // 5: M0 drops its request mid-access while M1 is pending
      m0_n = m0_idx + 1;
      m1_n = m1_idx + 1;
      @(negedge clk_i);
      drive_m(1'b0);
      drive_m(1'b1);
      #1;
      wait_sreq("t5_grant");
      check("t5_m0_first", s_addr_o, addr_of(1'b0, m0_idx));
      @(negedge clk_i);
      m0_req_i = 1'b0;
      m0_n     = m0_idx;
      #1;
      check("t5_s_req_follows", 32'(s_req_o), 32'd0);
      @(negedge clk_i); #1;
      check("t5_idle", 32'(busy_o), 32'd0);
      push_exp(1'b1, m1_idx);
      serve(2, 1);
      check("t5_m0_cnt", m0_cnt_o, exp_cnt[0]);

      // 6: saturation of the M0 counter
      do_reset();
      @(negedge clk_i);
      force dut.u_m0_cnt.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_m0_cnt.cnt_q;
      exp_cnt[0] = 32'hFFFF_FFFE;
      check("t6_preload", m0_cnt_o, exp_cnt[0]);
      m0_n = m0_idx + 3;
      for (int k = 0; k < 3; k++) push_exp(1'b0, m0_idx + k);
      @(negedge clk_i);
      drive_m(1'b0);
      #1;
      for (int k = 0; k < 3; k++) serve(1, 1);
      check("t6_saturated", m0_cnt_o, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_chk, n_pass);
      $fatal(1, "watchdog");
   end

endmodule
